// File: rtl/flag_wb_pkg.sv
// Shared types for the flag/writeback stage: condition encoding, flag register
// layout, skid-buffer states and the condition evaluator.
package flag_wb_pkg;

  typedef enum logic [3:0] {
    COND_NEVER = 4'd0,
    COND_EQ    = 4'd1,
    COND_NE    = 4'd2,
    COND_CS    = 4'd3,
    COND_CC    = 4'd4,
    COND_MI    = 4'd5,
    COND_PL    = 4'd6,
    COND_VS    = 4'd7,
    COND_VC    = 4'd8,
    COND_LT    = 4'd9,
    COND_GE    = 4'd10,
    COND_HI    = 4'd11
  } cond_e;

  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Selectors 12..15 are reserved and evaluate false.
  function automatic logic eval_cond(input flags_t f, input logic [3:0] sel);
    logic res;
    res = 1'b0;
    case (sel)
      COND_NEVER: res = 1'b0;
      COND_EQ:    res = f.z;
      COND_NE:    res = !f.z;
      COND_CS:    res = f.c;
      COND_CC:    res = !f.c;
      COND_MI:    res = f.s;
      COND_PL:    res = !f.s;
      COND_VS:    res = f.o;
      COND_VC:    res = !f.o;
      COND_LT:    res = (f.s != f.o);
      COND_GE:    res = (f.s == f.o);
      COND_HI:    res = f.c && !f.z;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry FIFO skid buffer with registered ready/valid; the upstream ready
// never depends combinationally on the downstream ready.
module wb_skid_buf
  import flag_wb_pkg::*;
#(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  skid_state_e state_r, state_next_s;
  logic [W-1:0] head_r, tail_r;
  logic ready_r, valid_r;
  logic push_s, pop_s;

  assign push_s     = push_valid && ready_r;
  assign pop_s      = valid_r && pop_ready;
  assign push_ready = ready_r;
  assign pop_valid  = valid_r;
  assign pop_data   = head_r;

  // Next-state logic for the occupancy FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) state_next_s = ST_ONE;
        else        state_next_s = ST_EMPTY;
      end
      ST_ONE: begin
        if (push_s && !pop_s)      state_next_s = ST_TWO;
        else if (!push_s && pop_s) state_next_s = ST_EMPTY;
        else                       state_next_s = ST_ONE;
      end
      ST_TWO: begin
        if (pop_s) state_next_s = ST_ONE;
        else       state_next_s = ST_TWO;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // State register; ready/valid are registered images of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s != ST_TWO);
      valid_r <= (state_next_s != ST_EMPTY);
    end
  end

  // Entry storage: head is always the oldest entry, tail only used in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: if (push_s) head_r <= push_data;
        ST_ONE: begin
          if (push_s && pop_s) head_r <= push_data;
          else if (push_s)     tail_r <= push_data;
        end
        ST_TWO: if (pop_s) head_r <= tail_r;
        default: head_r <= head_r;
      endcase
    end
  end

endmodule

// File: rtl/flag_wb_stage.sv
// Writeback stage: buffers {result,dest} for the register file and keeps the
// {O,C,S,Z} flag register. Define FLAG_WB_STATS_EN to add the wb_count output.
module flag_wb_stage
  import flag_wb_pkg::*;
#(
  parameter int BITS = 16,
  parameter int AW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] resu,
  input  logic            o,
  input  logic            c,
  input  logic            s,
  input  logic            flag_we,
  input  logic [AW-1:0]   dest,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [BITS-1:0] wb_data,
  output logic [AW-1:0]   wb_addr,
  output logic [3:0]      flags,
  input  logic [3:0]      cond,
`ifdef FLAG_WB_STATS_EN
  output logic [15:0]     wb_count,
`endif
  output logic            cond_true
);

  localparam int W = BITS + AW;

  flags_t flags_r;
  logic   push_s;

  assign push_s    = in_valid && in_ready;
  assign flags     = flags_r;
  assign cond_true = eval_cond(flags_r, cond);

  wb_skid_buf #(.W(W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({dest, resu}),
    .pop_valid  (wb_valid),
    .pop_ready  (wb_ready),
    .pop_data   ({wb_addr, wb_data})
  );

  // Flags follow the youngest accepted op; Z is derived here from the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= '0;
    end else if (push_s && flag_we) begin
      flags_r <= '{o: o, c: c, s: s, z: (resu == '0)};
    end
  end

`ifdef FLAG_WB_STATS_EN
  logic [15:0] wb_count_r;
  assign wb_count = wb_count_r;

  // Saturating count of retired entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_r <= 16'd0;
    end else if (wb_valid && wb_ready && (wb_count_r != 16'hFFFF)) begin
      wb_count_r <= wb_count_r + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flag_wb_stage.sv
// Directed self-checking bench for flag_wb_stage (BITS=16, AW=4).
module tb_flag_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] resu;
  logic        o, c, s, flag_we;
  logic [3:0]  dest;
  logic        wb_valid, wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_addr;
  logic [3:0]  flags;
  logic [3:0]  cond;
  logic        cond_true;
`ifdef FLAG_WB_STATS_EN
  logic [15:0] wb_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_wb_stage #(.BITS(16), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .resu      (resu),
    .o         (o),
    .c         (c),
    .s         (s),
    .flag_we   (flag_we),
    .dest      (dest),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_addr   (wb_addr),
    .flags     (flags),
    .cond      (cond),
`ifdef FLAG_WB_STATS_EN
    .wb_count  (wb_count),
`endif
    .cond_true (cond_true)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] d,
                       input logic fo, input logic fc, input logic fs, input logic we);
    in_valid = v; resu = r; dest = d; o = fo; c = fc; s = fs; flag_we = we;
  endtask

  task automatic check_cond(input string tag, input logic [3:0] sel, input logic exp);
    cond = sel;
    #1;
    check_val(tag, {31'd0, cond_true}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; wb_ready = 1'b0; cond = 4'd0;
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("rst_flags", {28'd0, flags}, 32'd0);
    step(); step();
    check_val("rst_wb_data", {16'd0, wb_data}, 32'd0);
    check_val("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    rst_n = 1'b1;
    check_val("rel_ready_pre", {31'd0, in_ready}, 32'd0);
    step();
    check_val("rel_ready_post", {31'd0, in_ready}, 32'd1);

    // Zero result sets Z locally.
    wb_ready = 1'b1;
    drive(1'b1, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("z_flags", {28'd0, flags}, 32'h5);
    check_val("z_valid", {31'd0, wb_valid}, 32'd1);
    check_val("z_data", {16'd0, wb_data}, 32'h0);
    check_val("z_addr", {28'd0, wb_addr}, 32'd3);
    check_cond("cond1", 4'd1, 1'b1);
    check_cond("cond2", 4'd2, 1'b0);
    check_cond("cond3", 4'd3, 1'b1);
    check_cond("cond0", 4'd0, 1'b0);
    step();
    check_val("z_empty", {31'd0, wb_valid}, 32'd0);

    // Back-pressure fills the buffer; third push is refused.
    wb_ready = 1'b0;
    drive(1'b1, 16'h0011, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_val("bp1_data", {16'd0, wb_data}, 32'h11);
    check_val("bp1_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 16'h0022, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_val("bp2_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h0033, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_val("bp3_ready", {31'd0, in_ready}, 32'd0);
    check_val("bp3_data", {16'd0, wb_data}, 32'h11);
    check_val("bp3_addr", {28'd0, wb_addr}, 32'd1);
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain in order.
    wb_ready = 1'b1;
    step();
    check_val("dr1_data", {16'd0, wb_data}, 32'h22);
    check_val("dr1_addr", {28'd0, wb_addr}, 32'd2);
    check_val("dr1_valid", {31'd0, wb_valid}, 32'd1);
    check_val("dr1_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_val("dr2_valid", {31'd0, wb_valid}, 32'd0);
    check_val("dr2_ready", {31'd0, in_ready}, 32'd1);
    check_val("we0_flags", {28'd0, flags}, 32'h5);

    // FLAG_WE=0 still writes back data but leaves flags alone.
    drive(1'b1, 16'h0055, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("we0_data", {16'd0, wb_data}, 32'h55);
    check_val("we0_flags2", {28'd0, flags}, 32'h5);
    step();

    // Overflow without sign: signed compares.
    drive(1'b1, 16'h0080, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check_val("ov_flags", {28'd0, flags}, 32'h8);
    check_cond("cond9", 4'd9, 1'b1);
    check_cond("cond10", 4'd10, 1'b0);
    check_cond("cond13", 4'd13, 1'b0);
    check_cond("cond7", 4'd7, 1'b1);
    check_cond("cond8", 4'd8, 1'b0);

    // Simultaneous push and pop in ONE.
    drive(1'b1, 16'h0099, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("pp_data", {16'd0, wb_data}, 32'h99);
    check_val("pp_valid", {31'd0, wb_valid}, 32'd1);
    check_val("pp_flags", {28'd0, flags}, 32'h6);
    check_cond("cond11", 4'd11, 1'b1);
    check_cond("cond12", 4'd12, 1'b0);
    check_cond("cond6", 4'd6, 1'b0);
    step();
    check_val("pp_empty", {31'd0, wb_valid}, 32'd0);
`ifdef FLAG_WB_STATS_EN
    check_val("count6", {16'd0, wb_count}, 32'd6);
`endif

    // Reset while full discards everything.
    wb_ready = 1'b0;
    drive(1'b1, 16'h00A1, 4'd10, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'h00A2, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("full_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("mr_valid", {31'd0, wb_valid}, 32'd0);
    check_val("mr_flags", {28'd0, flags}, 32'd0);
    check_val("mr_data", {16'd0, wb_data}, 32'd0);
`ifdef FLAG_WB_STATS_EN
    check_val("mr_count", {16'd0, wb_count}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    check_val("mr_ready", {31'd0, in_ready}, 32'd1);
    check_val("mr_valid2", {31'd0, wb_valid}, 32'd0);
    wb_ready = 1'b1;
    step();
    check_val("mr_valid3", {31'd0, wb_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
